// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - handshake sequencer for the 3-stage radix-16 Booth multiplier datapath
// Optional zero-operand bypass: define MULT_SEQ_ZERO_SKIP_EN.

module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 8,
  parameter int DRAIN = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_out,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_en,
  output logic                 mul_clr,
  output logic [3:0]           mul_count,
  output logic [3:0]           mul_preset,
  input  logic [2*WIDTH-1:0]   mul_out,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] win_cnt;
  logic [3:0] drain_cnt;
  logic       accept;
  logic       last_win;
  logic       last_drain;
  logic       zero_op;

  assign accept     = (state == S_IDLE) && req_valid;
  assign last_win   = (win_cnt == 4'(ITER - 1));
  assign last_drain = (drain_cnt == 4'(DRAIN - 1));

`ifdef MULT_SEQ_ZERO_SKIP_EN
  // A zero operand makes the product zero, so the datapath run is skipped
  assign zero_op = accept && ((req_a == '0) || (req_b == '0));
`else
  assign zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = zero_op ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (last_win) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_drain) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window index steps through ISSUE and holds at the last window during DRAIN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      win_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_ISSUE: begin
          if (!last_win) begin
            win_cnt <= win_cnt + 4'd1;
          end
          drain_cnt <= '0;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 4'd1;
        end
        default: begin
          win_cnt   <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Operand latch on accept and product capture once the accumulator has settled
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      res_out <= '0;
    end else begin
      if (accept) begin
        mul_a <= req_a;
        mul_b <= req_b;
      end
      if (zero_op) begin
        res_out <= '0;
      end else if ((state == S_DRAIN) && last_drain) begin
        res_out <= mul_out;
      end
    end
  end

  // Handshake and datapath control decode
  always_comb begin
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    mul_en     = 1'b0;
    mul_clr    = 1'b0;
    mul_preset = 4'd0;
    mul_count  = win_cnt;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        mul_en     = 1'b1;
        mul_clr    = 1'b1;
        mul_preset = 4'd1;
        mul_count  = 4'd0;
      end
      S_ISSUE: begin
        mul_en = 1'b1;
      end
      S_DRAIN: begin
        mul_en = 1'b1;
      end
      S_DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - scoreboard bench for mult_sequencer with a behavioural Booth datapath

module tb_mult_sequencer;

  localparam int W = 32;

  logic          Clk;
  logic          Reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_out;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_en;
  logic          mul_clr;
  logic [3:0]    mul_count;
  logic [3:0]    mul_preset;
  logic [63:0]   mul_out;
  logic          busy;

  mult_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_clr(mul_clr),
    .mul_count(mul_count), .mul_preset(mul_preset), .mul_out(mul_out), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event seen/missed at cycle %0d", name, cyc);
  endtask

  // Behavioural datapath: shift-A register, Booth register, accumulator
  logic [W-1:0]  a_reg;
  logic [63:0]   s1, acc;
  logic          s1v;
  int            issued;

  function automatic logic [63:0] term(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    longint ta;
    longint d;
    logic [3:0] nib;
    nib = b[4*c +: 4];
    ta = $signed(a);
    if (c == 7) d = $signed(nib);
    else        d = {60'd0, nib};
    return (ta * d) <<< (4 * c);
  endfunction

  always @(posedge Clk) begin
    if (!Reset) begin
      s1 <= '0; s1v <= 1'b0; acc <= '0; issued <= 0; a_reg <= '0;
    end else if (mul_en) begin
      if (mul_preset == 4'd1) a_reg <= mul_a;
      if (mul_clr) begin
        s1 <= '0; s1v <= 1'b0; acc <= '0; issued <= 0;
      end else begin
        s1v <= (issued < 8);
        if (issued < 8) begin
          s1 <= term(a_reg, mul_b, int'(mul_count));
          issued <= issued + 1;
        end
        if (s1v) acc <= acc + s1;
      end
    end
  end
  assign mul_out = acc;

  // Monitor: control sequence, latency, and result compare against the scoreboard
  int   acc_edge;
  int   kk;
  logic inflight = 1'b0;
  logic resp_open = 1'b0;
  logic prev_v = 1'b0;
  logic zop = 1'b0;
  int   exp_lat;
  logic [3:0] exp_cnt;

  always @(negedge Clk) begin
    if (!Reset) begin
      inflight = 1'b0; resp_open = 1'b0; prev_v = 1'b0;
    end else begin
      kk = cyc - acc_edge + 1;
      if (inflight && !res_valid) begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
        if (zop) check("zero_ctl", {62'd0, mul_en, mul_clr}, 64'd0);
        else
`endif
        if (kk >= 1 && kk <= 11) begin
          exp_cnt = (kk == 1) ? 4'd0 : (kk <= 9) ? 4'(kk - 2) : 4'd7;
          check("ctl_seq", {53'd0, busy, req_ready, mul_en, mul_clr, mul_preset, mul_count},
                {53'd0, 1'b1, 1'b0, 1'b1, (kk == 1), ((kk == 1) ? 4'd1 : 4'd0), exp_cnt});
        end
      end
      if (res_valid) begin
        if (!prev_v) begin
          if (!inflight || exp_q.size() == 0) fail_evt("res_valid_unexpected");
          else begin
            resp_open = 1'b1;
            exp_lat = 12;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if (zop) exp_lat = 1;
`endif
            check("latency", 64'(kk), 64'(exp_lat));
          end
        end
        if (!resp_open) fail_evt("res_valid_extra");
        else begin
          check("res_out", res_out, exp_q[0]);
          check("done_ctl", {61'd0, req_ready, mul_en, busy}, 64'd1);
          if (res_ready) begin
            void'(exp_q.pop_front());
            resp_open = 1'b0;
            inflight = 1'b0;
          end
        end
      end
      if (req_valid && req_ready) begin
        acc_edge = cyc + 1;
        inflight = 1'b1;
        zop = (req_a == '0) || (req_b == '0);
      end
      prev_v = res_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] prod);
    int t;
    t = 0;
    exp_q.push_back(prod);
    req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge Clk);
    while (!req_ready && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (!req_ready) fail_evt("accept_timeout");
    @(posedge Clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge Clk);
    while ((exp_q.size() != 0 || res_valid) && t < 60) begin
      @(negedge Clk);
      t++;
    end
    if (exp_q.size() != 0 || res_valid) fail_evt("result_timeout");
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, {51'd0, req_ready, res_valid, busy, mul_en, mul_clr, mul_count, mul_preset},
          {51'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
    check({tag, "_res_out"}, res_out, 64'd0);
    check({tag, "_mul_ab"}, {mul_a, mul_b}, 64'd0);
  endtask

  initial begin
    Reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check_reset_state("reset");
    @(posedge Clk); #1;

    send(32'h11111111, 32'h11111111, 64'h0123456787654321);
    wait_idle();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    wait_idle();
    send(32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_idle();
    send(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);
    wait_idle();
    send(32'h00000003, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1);
    wait_idle();

    // Backpressure with a second request pending
    res_ready = 1'b0;
    send(32'd2, 32'd3, 64'd6);
    begin
      int t;
      t = 0;
      @(negedge Clk);
      while (!res_valid && t < 40) begin
        @(negedge Clk);
        t++;
      end
      if (!res_valid) fail_evt("bp_valid_timeout");
    end
    @(posedge Clk); #1;
    exp_q.push_back(64'd56);
    req_a = 32'd7; req_b = 32'd8; req_valid = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check("bp_hold", {62'd0, req_ready, res_valid}, 64'd1);
    end
    @(posedge Clk); #1 res_ready = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("idle_after_done", {62'd0, req_ready, res_valid}, 64'd2);
    @(posedge Clk); #1 req_valid = 1'b0;
    wait_idle();

    // Zero operand: bypass or full datapath run depending on build
    send(32'h00000000, 32'h12345678, 64'd0);
    wait_idle();

    // Reset in the middle of ISSUE discards the operation
    send(32'd5, 32'd5, 64'd25);
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b0;
    exp_q.delete();
    @(posedge Clk); #1 Reset = 1'b1;
    @(negedge Clk);
    check_reset_state("mid_reset");
    repeat (20) @(negedge Clk);
    check("post_reset_quiet", {63'd0, res_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
